// File: rtl/axis_fifo_rd_master.sv
// Drains a FIFO read port into an AXI-Stream master, with tlast on every PKT_LEN-th beat.
// Latency: first beat appears 2 cycles after the FIFO turns non-empty; sustains 1 beat/cycle.
// Backpressure: a 3-entry buffer absorbs the read latency, so fifo_rd_en never depends on tready.
module axis_fifo_rd_master #(
   parameter int FIFO_WIDTH = 32,
   parameter int PKT_LEN    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tvalid,
   output logic [FIFO_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic [1:0]            buf_level
);

   // The beat counter needs at least one bit, even when every beat is a last beat.
   localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);

   logic [FIFO_WIDTH-1:0] buf_mem [3];
   logic [1:0]            wr_ptr;
   logic [1:0]            rd_ptr;
   logic [1:0]            occ;
   logic                  inflight;
   logic [CNT_W-1:0]      beat_cnt;

   logic                  pop;
   logic [2:0]            fill;
   logic [2:0]            occ_next;
   logic [FIFO_WIDTH-1:0] head_dat;

   // Advance a mod-3 pointer.
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Words already buffered plus the one in flight are the committed slots; issue
   // a read only while a slot remains, so capture can never find the buffer full.
   assign fill       = {1'b0, occ} + {2'b00, inflight};
   assign fifo_rd_en = !rst && !fifo_empty && (fill < 3'd3);

   assign m_axis_tvalid = (occ != 2'd0);
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign occ_next      = fill - {2'b00, pop};
   assign m_axis_tlast  = m_axis_tvalid && (beat_cnt == LAST_CNT);
   assign m_axis_tdata  = head_dat;
   assign buf_level     = occ;

   // Select the buffer head; the read pointer only ever holds 0..2.
   always_comb begin
      head_dat = buf_mem[2];
      case (rd_ptr)
         2'd0:    head_dat = buf_mem[0];
         2'd1:    head_dat = buf_mem[1];
         default: head_dat = buf_mem[2];
      endcase
   end

   // Capture the word returned by last cycle's read into the slot at wr_ptr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            buf_mem[i] <= '0;
         end
         wr_ptr <= 2'd0;
      end else if (inflight) begin
         buf_mem[wr_ptr] <= fifo_rd_data;
         wr_ptr          <= ptr_inc(wr_ptr);
      end
   end

   // Track the outstanding read and the buffer occupancy; capture and pop in the
   // same cycle cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight <= 1'b0;
         occ      <= 2'd0;
      end else begin
         inflight <= fifo_rd_en;
         occ      <= occ_next[1:0];
      end
   end

   // Retire the head on each handshake and count beats within the packet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= 2'd0;
         beat_cnt <= '0;
      end else if (pop) begin
         rd_ptr   <= ptr_inc(rd_ptr);
         beat_cnt <= m_axis_tlast ? '0 : beat_cnt + 1'b1;
      end
   end

   // The issue rule keeps the buffer from ever being over-committed.
   assert property (@(posedge clk) disable iff (rst) occ_next <= 3'd3);

endmodule

// File: tb/tb_axis_fifo_rd_master.sv
// Bench for axis_fifo_rd_master: a queue-based FIFO and output-buffer model predict every cycle.
// Two instances: PKT_LEN=16 (main) and PKT_LEN=1 (every beat last).
// Mix of directed phases and randomized tready/push traffic.
module tb_axis_fifo_rd_master;

   localparam int W       = 32;
   localparam int PKT_LEN = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         fifo_empty;
   logic [W-1:0] fifo_rd_data;
   logic         fifo_rd_en;
   logic         tready;
   logic         tvalid;
   logic [W-1:0] tdata;
   logic         tlast;
   logic [1:0]   buf_level;

   logic         fifo_empty1;
   logic [W-1:0] fifo_rd_data1;
   logic         fifo_rd_en1;
   logic         tready1;
   logic         tvalid1;
   logic [W-1:0] tdata1;
   logic         tlast1;
   logic [1:0]   buf_level1;

   always #5 clk = ~clk;

   axis_fifo_rd_master #(.FIFO_WIDTH(W), .PKT_LEN(PKT_LEN)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
      .fifo_rd_en(fifo_rd_en), .m_axis_tready(tready), .m_axis_tvalid(tvalid),
      .m_axis_tdata(tdata), .m_axis_tlast(tlast), .buf_level(buf_level));

   axis_fifo_rd_master #(.FIFO_WIDTH(W), .PKT_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty1), .fifo_rd_data(fifo_rd_data1),
      .fifo_rd_en(fifo_rd_en1), .m_axis_tready(tready1), .m_axis_tvalid(tvalid1),
      .m_axis_tdata(tdata1), .m_axis_tlast(tlast1), .buf_level(buf_level1));

   int n_vec = 0;
   int n_err = 0;

   // Environment FIFO contents, model output buffer, and words still owed to the sink.
   logic [W-1:0] fq[$];
   logic [W-1:0] mbuf[$];
   logic [W-1:0] log_q[$];
   logic         m_inf;
   logic [W-1:0] m_dat;
   int           beats;
   int           rd_pulses;
   int           vld_cycles;
   logic [W-1:0] fq1[$];
   logic [W-1:0] log1[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push(input logic [W-1:0] w);
      fq.push_back(w);
      log_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic push1(input logic [W-1:0] w);
      fq1.push_back(w);
      log1.push_back(w);
      fifo_empty1 = 1'b0;
   endtask

   // One clock: check outputs at the falling edge, then advance the model and the
   // environment FIFOs just after the rising edge.
   task automatic step();
      logic         e_rd, e_vld, e_last, e_hs, rd_seen, rd1_seen;
      logic [W-1:0] w;
      int           used;
      @(negedge clk);
      used   = mbuf.size() + (m_inf ? 1 : 0);
      e_rd   = (fq.size() != 0) && (used < 3);
      e_vld  = (mbuf.size() != 0);
      e_last = e_vld && ((beats % PKT_LEN) == PKT_LEN - 1);
      check("rd_en",     32'(fifo_rd_en), 32'(e_rd));
      check("tvalid",    32'(tvalid),     32'(e_vld));
      check("tlast",     32'(tlast),      32'(e_last));
      check("buf_level", 32'(buf_level),  32'(mbuf.size()));
      if (e_vld) begin
         check("tdata", tdata, mbuf[0]);
         if (log_q.size() > 0) check("order", tdata, log_q[0]);
      end
      e_hs       = e_vld && tready;
      rd_seen    = fifo_rd_en;
      rd_pulses  += fifo_rd_en ? 1 : 0;
      vld_cycles += tvalid ? 1 : 0;
      if (tvalid1) begin
         check("p1_tlast", 32'(tlast1), 32'd1);
         if (log1.size() > 0) begin
            w = log1.pop_front();
            check("p1_tdata", tdata1, w);
         end else begin
            check("p1_spurious", 32'(tvalid1), 32'd0);
         end
      end
      rd1_seen = fifo_rd_en1;
      @(posedge clk);
      #1;
      if (e_hs) begin
         w = mbuf.pop_front();
         if (log_q.size() > 0) w = log_q.pop_front();
         beats++;
      end
      if (m_inf) mbuf.push_back(m_dat);
      m_inf = e_rd;
      if (rd_seen && fq.size() > 0) begin
         w            = fq.pop_front();
         fifo_rd_data = w;
         m_dat        = w;
      end
      fifo_empty = (fq.size() == 0);
      if (rd1_seen && fq1.size() > 0) fifo_rd_data1 = fq1.pop_front();
      fifo_empty1 = (fq1.size() == 0);
   endtask

   initial begin
      int guard;
      rst = 1'b1;
      fifo_empty = 1'b1;    fifo_rd_data = '0;
      fifo_empty1 = 1'b1;   fifo_rd_data1 = '0;
      tready = 1'b0;        tready1 = 1'b1;
      m_inf = 1'b0;         m_dat = '0;
      beats = 0;            rd_pulses = 0;   vld_cycles = 0;

      // Reset state, with a word waiting so rd_en must be held low by reset itself.
      push(32'hA5A5_0001);
      @(negedge clk);
      check("rst_tvalid", 32'(tvalid),     32'd0);
      check("rst_tlast",  32'(tlast),      32'd0);
      check("rst_rd_en",  32'(fifo_rd_en), 32'd0);
      check("rst_level",  32'(buf_level),  32'd0);
      check("rst_tdata",  tdata,           32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Single word.
      tready = 1'b1;
      repeat (6) step();
      check("single_rd",  32'(rd_pulses),  32'd1);
      check("single_vld", 32'(vld_cycles), 32'd1);

      // Streaming 32 words with no gaps.
      vld_cycles = 0;
      for (int i = 0; i < 32; i++) push(32'(i));
      repeat (40) step();
      check("stream_vld", 32'(vld_cycles), 32'd32);

      // Backpressure: only 3 reads while the sink stalls.
      tready = 1'b0;
      rd_pulses = 0;
      for (int i = 0; i < 10; i++) push(32'(i));
      repeat (20) step();
      check("bp_rd",    32'(rd_pulses), 32'd3);
      check("bp_level", 32'(buf_level), 32'd3);
      check("bp_tdata", tdata,          32'd0);
      for (int i = 0; i < 40; i++) begin
         tready = (i % 2) == 0;
         step();
      end
      check("bp_all_out", 32'(log_q.size()), 32'd0);

      // FIFO runs dry with one read in flight and two words buffered.
      tready = 1'b0;
      for (int i = 0; i < 3; i++) push(32'hC0DE_0000 + 32'(i));
      repeat (6) step();
      tready = 1'b1;
      repeat (6) step();
      check("corner_level", 32'(buf_level),     32'd0);
      check("corner_out",   32'(log_q.size()),  32'd0);

      // Randomized traffic on both instances.
      for (int i = 0; i < 400; i++) begin
         tready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) != 0) push($urandom);
         if (i < 40 && $urandom_range(0, 1) == 0) push1(32'h1000 + 32'(i));
         if (i == 50) for (int k = 0; k < 4; k++) push1(32'h2000 + 32'(k));
         step();
      end
      tready = 1'b1;
      repeat (300) step();
      check("rand_out", 32'(log_q.size()), 32'd0);
      check("p1_out",   32'(log1.size()),  32'd0);

      // Reset asserted mid-cycle while beat 5 of a packet is presented.
      for (int i = 0; i < 20; i++) push(32'hB000_0000 + 32'(i));
      guard = 0;
      while ((beats % PKT_LEN) != 5 && guard < 100) begin
         step();
         guard++;
      end
      check("reach_beat5", 32'(beats % PKT_LEN), 32'd5);
      #3 rst = 1'b1;
      #1;
      check("mid_tvalid", 32'(tvalid),     32'd0);
      check("mid_rd_en",  32'(fifo_rd_en), 32'd0);
      check("mid_level",  32'(buf_level),  32'd0);
      check("mid_tlast",  32'(tlast),      32'd0);
      fq.delete();  mbuf.delete();  log_q.delete();
      fq1.delete(); log1.delete();
      m_inf = 1'b0; beats = 0;
      fifo_empty = 1'b1; fifo_empty1 = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 20; i++) push(32'hD000_0000 + 32'(i));
      repeat (30) step();
      check("post_rst_out",   32'(log_q.size()), 32'd0);
      check("post_rst_beats", 32'(beats),        32'd20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
